eth_tx_sequencer: RTL and testbench
===================================

Name: eth_tx_sequencer

Overview:
Transmit-side sequencer between the upper layer (mcu/cpu byte stream) and the MAC/MII byte datapath.
- Accepts one frame's payload bytes per handshake.
- Wraps the payload with preamble, SFD, zero padding to minimum length and a CRC-32 FCS.
- Enforces the inter-frame gap before accepting the next frame.
- Registered outputs drive the MII transmit byte lane.

Parameters:
MIN_PAYLOAD, 60, minimum bytes (payload+pad) before FCS; shorter payloads are zero-padded.
MAX_PAYLOAD, 1514, maximum accepted payload bytes; exceeding this aborts the frame.
IFG_BYTES, 12, idle byte-times enforced after each frame or abort.

Ports:
clk  in  1  byte clock.
rst  in  1  synchronous reset, active-high.
in_txen  in  1  upper layer has a valid byte on in_txd.
in_txd  in  8  payload byte.
in_txlast  in  1  qualifies in_txd as the last payload byte.
out_txready  out  1  sequencer consumes in_txd this cycle when in_txen=1.
out_txen  out  1  MII transmit enable.
out_txd  out  8  MII transmit byte.
out_txer  out  1  MII transmit error, 1-cycle pulse on abort.
out_busy  out  1  high in every state except IDLE.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values: all outputs 0; state IDLE; CRC register 0xFFFFFFFF; counters 0.
- rst asserted mid-frame: outputs are 0 on the next edge. No FCS or error is emitted for the truncated frame.
- Handshake: a byte transfers on a cycle where in_txen=1 and out_txready=1. out_txready is high only in DATA.
- States and transitions:
  - IDLE: in_txen=1 → PREAMBLE. The pending byte is not consumed.
  - PREAMBLE: 7 cycles of out_txd=0x55 → SFD.
  - SFD: 1 cycle of out_txd=0xD5 → DATA.
  - DATA:
    - Each transfer: out_txd=in_txd on the next cycle, CRC updated, byte counter incremented.
    - Transfer with in_txlast=1: → PAD if count < MIN_PAYLOAD, else → FCS.
    - in_txen=0 in DATA (underrun): out_txer=1 for 1 cycle, out_txen=0, → IFG.
    - A transfer that would make count > MAX_PAYLOAD: same abort; the byte is not transmitted.
  - PAD: out_txd=0x00, CRC updated, until count = MIN_PAYLOAD → FCS.
  - FCS: 4 cycles. out_txd = ~CRC, least-significant byte first → IFG.
  - IFG: out_txen=0 for IFG_BYTES cycles → IDLE. in_txen is ignored.
- Latency: in_txen rising in IDLE at cycle N gives first 0x55 at cycle N+1. The first payload byte appears on out_txd 9 cycles after the frame start (8 header cycles).
- out_txen is high continuously from the first preamble byte through the last FCS byte.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per cycle.
  - Covers payload and pad only; preamble and SFD are excluded.
  - Re-initialised on entry to PREAMBLE.
- Byte counter: 11 bits, saturating. Compares are unsigned.
- in_txlast without in_txen is ignored.
- A zero-length frame is impossible; the first accepted byte is always payload.
- Frame start and a same-cycle rst: rst wins.

Decomposition:
- Package eth_pkg holds:
  - state enum {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG}
  - PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_POLY=0xEDB88320, CRC_INIT=0xFFFFFFFF, PREAMBLE_LEN=7.
- Sub-module eth_crc32: combinational byte-wise next-CRC function.
  - Inputs: crc[31:0], data[7:0]. Output: next crc.
  - Instanced once; the CRC register stays in the sequencer.

Test Plan:
1. MIN_PAYLOAD=0, payload ASCII "123456789" (last on '9') → out_txd is 55×7, D5, 31..39, then 26 39 F4 CB. out_txen high exactly 21 cycles, then 12 idle cycles.
2. Default params, single payload byte 0xAA → 7+1 header bytes, AA, 59 bytes of 00, 4 FCS bytes matching the model. out_txen high 72 cycles.
3. in_txen dropped after 10 DATA bytes → out_txer pulses 1 cycle, no FCS, out_txready=0 for 12 IFG cycles, next frame starts normally.
4. 1515-byte stream with no in_txlast → byte 1515 not transmitted, out_txer pulse, → IFG.
5. Back-to-back frames with in_txen held high → second preamble starts exactly 13 cycles after the last FCS byte (12 IFG + 1 IDLE).
6. rst asserted during FCS byte 2 → next cycle out_txen=0, out_txd=0, out_busy=0. A new frame afterwards has a correct FCS.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet transmit sequencer.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } eth_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam int          PREAMBLE_LEN  = 7;
  localparam int          CNT_W         = 11;

  // FCS byte idx (0 = first on the wire) of the inverted CRC register.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] fcs;
    logic [7:0]  res;
    fcs = ~crc;
    case (idx)
      2'd0:    res = fcs[7:0];
      2'd1:    res = fcs[15:8];
      2'd2:    res = fcs[23:16];
      default: res = fcs[31:24];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/eth_crc32.sv
// Combinational byte-wise CRC-32 step (reflected polynomial, LSB first).
module eth_crc32
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  // Fold the byte into the low bits, then run eight reflected shift steps.
  always_comb begin
    logic [31:0] c;
    c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/eth_tx_sequencer.sv
// Transmit sequencer: wraps an upper-layer byte stream with preamble, SFD,
// zero padding and CRC-32 FCS, then enforces the inter-frame gap.
//
// Handshake: a payload byte moves when in_txen=1 and out_txready=1 in the same
// cycle; out_txready depends only on the current state (high only in DATA), so
// the upper layer never sees it react to in_txen within a cycle.
//
// The state register names the byte the next edge will put on the MII lane, so
// the visible bytes lag the state by one cycle: IDLE launches preamble byte 1,
// PREAMBLE launches bytes 2..7, SFD launches 0xD5, and DATA is the cycle in
// which 0xD5 is on the wire and the first payload byte is accepted.
module eth_tx_sequencer
  import eth_pkg::*;
#(
  parameter int MIN_PAYLOAD = 60,
  parameter int MAX_PAYLOAD = 1514,
  parameter int IFG_BYTES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_txen,
  input  logic [7:0] in_txd,
  input  logic       in_txlast,
  output logic       out_txready,
  output logic       out_txen,
  output logic [7:0] out_txd,
  output logic       out_txer,
  output logic       out_busy,
  output eth_state_e out_dbg_state
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  // Both sides shifted by one so a zero minimum never produces a compare with 0.
  localparam logic [CNT_W:0]   MIN_P1   = (CNT_W + 1)'(MIN_PAYLOAD + 1);

  eth_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic             txen_q;
  logic [7:0]       txd_q;
  logic             txer_q;

  logic [CNT_W-1:0] cnt_inc;
  logic             short_frame;
  logic [7:0]       crc_data;

  // Saturating byte count and the "still below minimum length" test after this byte.
  always_comb begin
    cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    short_frame = ({1'b0, cnt_inc} + 1'b1) < MIN_P1;
    crc_data    = (state_q == PAD) ? 8'h00 : in_txd;
  end

  eth_crc32 u_crc (
    .crc_i  (crc_q),
    .data_i (crc_data),
    .crc_o  (crc_d)
  );

  // Frame sequencing FSM with registered MII outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      txen_q  <= 1'b0;
      txd_q   <= 8'h00;
      txer_q  <= 1'b0;
    end else begin
      txer_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txen_q <= 1'b0;
          txd_q  <= 8'h00;
          if (in_txen) begin
            // Pending byte stays on in_txd until DATA accepts it.
            state_q <= PREAMBLE;
            txen_q  <= 1'b1;
            txd_q   <= PREAMBLE_BYTE;
            cnt_q   <= CNT_W'(1);
            crc_q   <= CRC_INIT;
          end
        end
        PREAMBLE: begin
          txd_q <= PREAMBLE_BYTE;
          if (cnt_q >= PRE_LAST) begin
            state_q <= SFD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        SFD: begin
          txd_q   <= SFD_BYTE;
          state_q <= DATA;
          cnt_q   <= '0;
        end
        DATA: begin
          if (!in_txen || (cnt_q >= MAX_CNT)) begin
            // Underrun or oversize: drop the frame, no FCS, flag the error.
            txen_q  <= 1'b0;
            txd_q   <= 8'h00;
            txer_q  <= 1'b1;
            state_q <= IFG;
            cnt_q   <= '0;
          end else begin
            txd_q <= in_txd;
            crc_q <= crc_d;
            cnt_q <= cnt_inc;
            if (in_txlast) begin
              if (short_frame) begin
                state_q <= PAD;
              end else begin
                state_q <= FCS;
                cnt_q   <= '0;
              end
            end
          end
        end
        PAD: begin
          txd_q <= 8'h00;
          crc_q <= crc_d;
          if (short_frame) begin
            cnt_q <= cnt_inc;
          end else begin
            state_q <= FCS;
            cnt_q   <= '0;
          end
        end
        FCS: begin
          txd_q <= fcs_byte(crc_q, cnt_q[1:0]);
          if (cnt_q[1:0] == 2'd3) begin
            state_q <= IFG;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        IFG: begin
          txen_q <= 1'b0;
          txd_q  <= 8'h00;
          if (cnt_q >= IFG_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          txen_q  <= 1'b0;
          txd_q   <= 8'h00;
        end
      endcase
    end
  end

  assign out_txready   = (state_q == DATA);
  assign out_busy      = (state_q != IDLE);
  assign out_txen      = txen_q;
  assign out_txd       = txd_q;
  assign out_txer      = txer_q;
  assign out_dbg_state = state_q;

endmodule

// File: tb/tb_eth_tx_sequencer.sv
// Self-checking bench for eth_tx_sequencer: a per-cycle vector table on a
// MIN_PAYLOAD=0 instance plus frame-level sequences on a default instance.
module tb_eth_tx_sequencer;
  import eth_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic       in_txen = 1'b0;
  logic [7:0] in_txd = 8'h00;
  logic       in_txlast = 1'b0;
  logic       out_txready, out_txen, out_txer, out_busy;
  logic [7:0] out_txd;
  eth_state_e out_st;

  // MIN_PAYLOAD=0 instance for the unpadded check-value frame
  logic       in0_txen = 1'b0;
  logic [7:0] in0_txd = 8'h00;
  logic       in0_txlast = 1'b0;
  logic       o0_txready, o0_txen, o0_txer, o0_busy;
  logic [7:0] o0_txd;
  eth_state_e o0_st;

  eth_tx_sequencer dut (
    .clk(clk), .rst(rst),
    .in_txen(in_txen), .in_txd(in_txd), .in_txlast(in_txlast),
    .out_txready(out_txready), .out_txen(out_txen), .out_txd(out_txd),
    .out_txer(out_txer), .out_busy(out_busy), .out_dbg_state(out_st)
  );

  eth_tx_sequencer #(.MIN_PAYLOAD(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_txen(in0_txen), .in_txd(in0_txd), .in_txlast(in0_txlast),
    .out_txready(o0_txready), .out_txen(o0_txen), .out_txd(o0_txd),
    .out_txer(o0_txer), .out_busy(o0_busy), .out_dbg_state(o0_st)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pl[0:1599];
  int         er_cnt = 0;

  always @(negedge clk) begin
    if (out_txen) got_q.push_back(out_txd);
    if (out_txer) er_cnt++;
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ b[i]) c = {1'b0, c[31:1]} ^ 32'hEDB88320;
      else             c = {1'b0, c[31:1]};
    end
    return c;
  endfunction

  task automatic fill_payload(input int seed);
    for (int i = 0; i < 1600; i++) pl[i] = 8'(i * 37 + seed);
  endtask

  // Wire image of a frame: header, n_sent payload bytes, pad and n_fcs FCS bytes.
  task automatic expect_frame(input int n_sent, input bit complete, input int n_fcs);
    logic [31:0] c;
    int n;
    c = 32'hFFFFFFFF;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n_sent; i++) begin
      exp_q.push_back(pl[i]);
      c = crc_upd(c, pl[i]);
    end
    if (complete) begin
      n = n_sent;
      while (n < 60) begin
        exp_q.push_back(8'h00);
        c = crc_upd(c, 8'h00);
        n++;
      end
      c = ~c;
      for (int i = 0; i < n_fcs; i++) exp_q.push_back(c[8*i +: 8]);
    end
  endtask

  task automatic compare_q(input string name);
    int nmis;
    int first;
    nmis  = 0;
    first = -1;
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        nmis++;
        if (first < 0) first = i;
      end
    end
    check({name, "_bytes_differing"}, nmis, 0);
    if (first >= 0) $display("  %s first differing byte index %0d", name, first);
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input int len, input bit use_last, input int stop_at, input bit hold);
    int idx;
    int guard;
    bit stopped;
    idx = 0;
    guard = 0;
    stopped = 1'b0;
    while (idx < len && guard < 5000) begin
      @(negedge clk);
      if (idx == stop_at) begin
        stopped = 1'b1;
        break;
      end
      in_txen   = 1'b1;
      in_txd    = pl[idx];
      in_txlast = use_last && (idx == len - 1);
      if (out_txready) idx++;
      guard++;
    end
    check("send_cycle_budget", (guard < 5000), 1);
    if (stopped) begin
      in_txen   = 1'b0;
      in_txlast = 1'b0;
    end else begin
      @(negedge clk);
      in_txen   = hold;
      in_txd    = hold ? pl[0] : 8'h00;
      in_txlast = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (out_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reaches_idle"}, out_busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       txen;
    logic [7:0] txd;
    logic       last;
    logic       e_txen;
    logic [7:0] e_txd;
    logic       e_rdy;
    logic       e_busy;
    logic       e_er;
    eth_state_e e_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic txen, input logic [7:0] txd, input logic last,
                         input logic e_txen, input logic [7:0] e_txd, input logic e_rdy,
                         input logic e_busy, input logic e_er, input eth_state_e e_st);
    vec_t v;
    v.txen = txen; v.txd = txd; v.last = last;
    v.e_txen = e_txen; v.e_txd = e_txd; v.e_rdy = e_rdy;
    v.e_busy = e_busy; v.e_er = e_er; v.e_st = e_st;
    vecs.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int er0;
    int last_hi;
    int rise;
    bit fell;
    logic [7:0] fcs_b2;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_dut_outputs", {out_txen, out_txd, out_txready, out_busy, out_txer, out_st}, 0);
    check("reset_dut0_outputs", {o0_txen, o0_txd, o0_txready, o0_busy, o0_txer, o0_st}, 0);
    rst = 1'b0;

    // Test 1 (MIN_PAYLOAD=0): "123456789" -> FCS 26 39 F4 CB, then IFG, then an underrun frame.
    add_vec(1, 8'h31, 0,  0, 8'h00, 0, 0, 0, IDLE);                       // c0
    for (int k = 1; k <= 6; k++) add_vec(1, 8'h31, 0,  1, 8'h55, 0, 1, 0, PREAMBLE);
    add_vec(1, 8'h31, 0,  1, 8'h55, 0, 1, 0, SFD);                        // c7
    add_vec(1, 8'h31, 0,  1, 8'hD5, 1, 1, 0, DATA);                       // c8
    for (int k = 0; k < 8; k++)                                           // c9..c16
      add_vec(1, 8'(8'h32 + k), (k == 7),  1, 8'(8'h31 + k), 1, 1, 0, DATA);
    add_vec(0, 8'h00, 0,  1, 8'h39, 0, 1, 0, FCS);                        // c17
    add_vec(0, 8'h00, 0,  1, 8'h26, 0, 1, 0, FCS);
    add_vec(0, 8'h00, 0,  1, 8'h39, 0, 1, 0, FCS);
    add_vec(0, 8'h00, 0,  1, 8'hF4, 0, 1, 0, FCS);
    add_vec(0, 8'h00, 0,  1, 8'hCB, 0, 1, 0, IFG);                        // c21
    for (int k = 0; k < 11; k++)                                          // c22..c32, in_txen ignored
      add_vec(1, 8'h31, 0,  0, 8'h00, 0, 1, 0, IFG);
    add_vec(1, 8'h31, 0,  0, 8'h00, 0, 0, 0, IDLE);                       // c33
    for (int k = 0; k < 6; k++)                                           // c34..c39
      add_vec(0, 8'h00, 0,  1, 8'h55, 0, 1, 0, PREAMBLE);
    add_vec(0, 8'h00, 0,  1, 8'h55, 0, 1, 0, SFD);                        // c40
    add_vec(0, 8'h00, 0,  1, 8'hD5, 1, 1, 0, DATA);                       // c41 underrun
    add_vec(0, 8'h00, 0,  0, 8'h00, 0, 1, 1, IFG);                        // c42 error pulse
    add_vec(0, 8'h00, 0,  0, 8'h00, 0, 1, 0, IFG);                        // c43

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("t1_vec%0d", i),
            {o0_txen, o0_txd, o0_txready, o0_busy, o0_txer, o0_st},
            {vecs[i].e_txen, vecs[i].e_txd, vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_er, vecs[i].e_st});
      in0_txen   = vecs[i].txen;
      in0_txd    = vecs[i].txd;
      in0_txlast = vecs[i].last;
    end
    in0_txen = 1'b0;
    in0_txlast = 1'b0;

    // Test 2: single byte 0xAA, padded to 60, 72 cycles of out_txen
    fill_payload(5);
    pl[0] = 8'hAA;
    er0 = er_cnt;
    send_frame(1, 1'b1, -1, 1'b0);
    expect_frame(1, 1'b1, 4);
    wait_idle("t2");
    check("t2_txen_cycles", got_q.size(), 72);
    compare_q("t2_frame");
    check("t2_no_txer", er_cnt - er0, 0);

    // Test 3: underrun after 10 DATA bytes, IFG, then a normal frame
    fill_payload(11);
    er0 = er_cnt;
    send_frame(20, 1'b1, 10, 1'b0);
    expect_frame(10, 1'b0, 0);
    @(negedge clk);
    check("t3_abort_cycle", {out_txen, out_txer, out_txready, out_busy}, 4'b0101);
    in_txen = 1'b1;
    in_txd  = pl[0];
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      check($sformatf("t3_ifg_cycle%0d", k), {out_txen, out_txer, out_txready, out_busy}, 4'b0001);
    end
    @(negedge clk);
    check("t3_idle_after_ifg", {out_txen, out_busy}, 2'b00);
    compare_q("t3_aborted_frame");
    check("t3_txer_pulses", er_cnt - er0, 1);
    @(negedge clk);
    check("t3_next_preamble", {out_txen, out_txd}, {1'b1, 8'h55});
    send_frame(20, 1'b1, -1, 1'b0);
    expect_frame(20, 1'b1, 4);
    wait_idle("t3_next");
    compare_q("t3_next_frame");

    // Test 4: 1515 bytes with no last flag -> byte 1515 dropped, error pulse
    fill_payload(3);
    er0 = er_cnt;
    send_frame(1515, 1'b0, -1, 1'b0);
    expect_frame(1514, 1'b0, 0);
    wait_idle("t4");
    compare_q("t4_oversize");
    check("t4_txer_pulses", er_cnt - er0, 1);

    // Test 5: back-to-back frames with in_txen held high
    fill_payload(77);
    send_frame(60, 1'b1, -1, 1'b1);
    expect_frame(60, 1'b1, 4);
    last_hi = -1;
    rise = -1;
    fell = 1'b0;
    for (int i = 0; i < 100 && rise < 0; i++) begin
      if (i > 0) @(negedge clk);
      if (out_txen) begin
        if (fell) rise = i;
        else      last_hi = i;
      end else begin
        fell = 1'b1;
      end
    end
    check("t5_gap_cycles", rise - last_hi, 13);
    check("t5_second_preamble", out_txd, 8'h55);
    send_frame(60, 1'b1, -1, 1'b0);
    expect_frame(60, 1'b1, 4);
    wait_idle("t5");
    compare_q("t5_two_frames");

    // Test 6: reset during FCS byte 2, then a clean frame
    fill_payload(200);
    send_frame(60, 1'b1, -1, 1'b0);
    expect_frame(60, 1'b1, 2);
    fcs_b2 = exp_q[$];
    @(negedge clk);
    @(negedge clk);
    check("t6_fcs_byte2", {out_txen, out_txd}, {1'b1, fcs_b2});
    rst = 1'b1;
    @(negedge clk);
    check("t6_after_reset", {out_txen, out_txd, out_txready, out_busy, out_txer, out_st}, 0);
    rst = 1'b0;
    compare_q("t6_truncated");
    fill_payload(9);
    send_frame(5, 1'b1, -1, 1'b0);
    expect_frame(5, 1'b1, 4);
    wait_idle("t6_new");
    compare_q("t6_new_frame");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
